// File: rtl/uart_pkg.sv
// Shared UART constants: default baud generator parameters and a width helper.
package uart_pkg;

  localparam int UART_DIV_W      = 16;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_RESET  = 0;

  // Width of a counter holding 0..os-1 when os is a power of two.
  function automatic int os_cnt_w(input int os);
    return $clog2(os);
  endfunction

endpackage

// File: rtl/baud_modcnt.sv
// Modulo counter with synchronous clear, count enable, run-time modulus and a
// registered wrap pulse that is high for the cycle after each wrap edge.
module baud_modcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] cnt,
  output logic         wrap_now,
  output logic         wrap_q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap_d;

  always_comb begin
    wrap_d = inc && !clr && (cnt_q == modulus - W'(1));
    cnt_d  = cnt_q;
    if (clr || wrap_d) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt      = cnt_q;
  assign wrap_now = wrap_d;

endmodule

// File: rtl/baud_gen.sv
// UART baud generator: divisor prescaler feeding an oversample counter, with
// divisor changes deferred to a prescaler wrap so no period is ever shortened.
module baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_RESET  = UART_DIV_RESET
) (
  input  logic             clk_cpu,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_wr,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             baud_clock,
  output logic             div_zero
);

  localparam int OS_W = os_cnt_w(OVERSAMPLE);
  // One spare bit so the modulus value OVERSAMPLE itself is representable.
  localparam logic [OS_W:0] OS_MOD  = (OS_W+1)'(OVERSAMPLE);
  localparam logic [OS_W:0] OS_HALF = (OS_W+1)'(OVERSAMPLE / 2);

  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic             div_zero_q, div_zero_d;
  logic             baud_clock_q, baud_clock_d;
  logic             running;
  logic [DIV_W-1:0] pre_cnt;
  logic             pre_wrap;
  logic [OS_W:0]    os_cnt;
  logic [OS_W:0]    os_cnt_nxt;
  logic             os_wrap;
  logic             unused_pre;

  assign running    = en && (div_act_q != '0);
  assign unused_pre = ^pre_cnt;

  baud_modcnt #(.W(DIV_W)) u_pre (
    .clk      (clk_cpu),
    .rst_n    (rst),
    .clr      (!running),
    .inc      (running),
    .modulus  (div_act_q),
    .cnt      (pre_cnt),
    .wrap_now (pre_wrap),
    .wrap_q   (os_tick)
  );

  baud_modcnt #(.W(OS_W + 1)) u_os (
    .clk      (clk_cpu),
    .rst_n    (rst),
    .clr      (!running),
    .inc      (pre_wrap),
    .modulus  (OS_MOD),
    .cnt      (os_cnt),
    .wrap_now (os_wrap),
    .wrap_q   (baud_tick)
  );

  always_comb begin
    os_cnt_nxt   = os_wrap ? '0 : os_cnt + (OS_W+1)'(1);
    div_pend_d   = div_wr ? div_in : div_pend_q;
    div_act_d    = div_act_q;
    baud_clock_d = baud_clock_q;
    if (!running) begin
      div_act_d    = div_pend_q;
      baud_clock_d = 1'b1;
    end else if (pre_wrap) begin
      // A write landing on the wrap edge bypasses div_pend and governs the next period.
      div_act_d    = div_wr ? div_in : div_pend_q;
      baud_clock_d = (os_cnt_nxt < OS_HALF);
    end
    div_zero_d = (div_act_d == '0);
  end

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      div_pend_q   <= DIV_W'(DIV_RESET);
      div_act_q    <= DIV_W'(DIV_RESET);
      div_zero_q   <= (DIV_RESET == 0);
      baud_clock_q <= 1'b1;
    end else begin
      div_pend_q   <= div_pend_d;
      div_act_q    <= div_act_d;
      div_zero_q   <= div_zero_d;
      baud_clock_q <= baud_clock_d;
    end
  end

  assign baud_clock = baud_clock_q;
  assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_baud_gen.sv
// Scoreboard bench for baud_gen: a cycle model queues expected outputs per
// driven cycle; directed scenarios also check tick spacing and latency.
module tb_baud_gen;

  localparam int OS = 16;

  typedef struct packed {
    logic ost;
    logic bt;
    logic bc;
    logic dz;
  } exp_t;

  logic        clk_cpu = 1'b0;
  logic        rst     = 1'b1;
  logic        en      = 1'b0;
  logic [15:0] div_in  = '0;
  logic        div_wr  = 1'b0;
  logic        os_tick, baud_tick, baud_clock, div_zero;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  int   ost_q[$];
  int   bt_q[$];
  int   bc_q[$];
  logic bc_prev = 1'b1;

  int m_pend, m_act, m_pre, m_os;
  bit m_ost, m_bt, m_bc, m_dz;

  baud_gen #(.DIV_W(16), .OVERSAMPLE(OS), .DIV_RESET(0)) dut (
    .clk_cpu    (clk_cpu),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_wr     (div_wr),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .baud_clock (baud_clock),
    .div_zero   (div_zero)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int gap(input int q[$], input int i);
    if (i + 1 < q.size()) return q[i+1] - q[i];
    return -1;
  endfunction

  function automatic int first(input int q[$]);
    if (q.size() > 0) return q[0];
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_act = 0; m_pre = 0; m_os = 0;
    m_ost = 0; m_bt = 0; m_bc = 1; m_dz = 1;
  endtask

  task automatic model_step(input bit e, input bit w, input int d);
    int nact;
    bit run, wrap;
    run = e && (m_act != 0);
    if (run) begin
      wrap  = (m_pre == m_act - 1);
      m_ost = wrap;
      m_bt  = wrap && (m_os == OS - 1);
      if (wrap) begin
        m_pre = 0;
        m_os  = (m_os + 1) % OS;
        m_bc  = (m_os < OS / 2);
        nact  = w ? d : m_pend;
      end else begin
        m_pre = m_pre + 1;
        nact  = m_act;
      end
    end else begin
      m_pre = 0; m_os = 0; m_ost = 0; m_bt = 0; m_bc = 1;
      nact  = m_pend;
    end
    if (w) m_pend = d;
    m_act = nact;
    m_dz  = (m_act == 0);
  endtask

  task automatic cycle(input logic e, input logic w, input int d);
    exp_t x;
    en = e; div_wr = w; div_in = 16'(d);
    model_step(e, w, d);
    x = '{ost: m_ost, bt: m_bt, bc: m_bc, dz: m_dz};
    sb_q.push_back(x);
    @(posedge clk_cpu);
    #1;
    cyc++;
    x = sb_q.pop_front();
    chk($sformatf("outs@%0d", cyc), int'({os_tick, baud_tick, baud_clock, div_zero}), int'(x));
    if (os_tick)   ost_q.push_back(cyc);
    if (baud_tick) bt_q.push_back(cyc);
    if (baud_clock !== bc_prev) bc_q.push_back(cyc);
    bc_prev = baud_clock;
  endtask

  task automatic clr_cap();
    ost_q.delete();
    bt_q.delete();
    bc_q.delete();
    bc_prev = baud_clock;
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", int'({os_tick, baud_tick, baud_clock, div_zero}), 4'b0011);
    model_reset();
    @(posedge clk_cpu);
    #1;
    chk("held_rst_outs", int'({os_tick, baud_tick, baud_clock, div_zero}), 4'b0011);
    rst = 1'b1;
    bc_prev = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cyc, ld;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_outs", int'({os_tick, baud_tick, baud_clock, div_zero}), 4'b0011);
    @(posedge clk_cpu);
    #1;
    rst = 1'b1;

    // D=4: tick spacing and baud_clock duty
    cycle(0, 1, 4);
    cycle(0, 0, 0);
    chk("d4_div_zero", int'(div_zero), 0);
    clr_cap();
    en_cyc = cyc + 1;
    repeat (140) cycle(1, 0, 0);
    chk("d4_latency", first(ost_q) - en_cyc, 3);
    chk("d4_ost_gap", gap(ost_q, 0), 4);
    chk("d4_bt_gap", gap(bt_q, 0), 64);
    chk("d4_bc_low", gap(bc_q, 0), 32);
    chk("d4_bc_high", gap(bc_q, 1), 32);

    // D=1: os_tick held high
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    clr_cap();
    en_cyc = cyc + 1;
    repeat (40) cycle(1, 0, 0);
    chk("d1_ost_count", ost_q.size(), 40);
    chk("d1_bt_gap", gap(bt_q, 0), 16);
    chk("d1_bc_gap", gap(bc_q, 0), 8);

    // D=10 with a write of 3 mid-period
    cycle(0, 1, 10);
    cycle(0, 0, 0);
    clr_cap();
    en_cyc = cyc + 1;
    repeat (25) cycle(1, 0, 0);
    cycle(1, 1, 3);
    repeat (20) cycle(1, 0, 0);
    chk("d10_latency", first(ost_q) - en_cyc, 9);
    chk("d10_gap0", gap(ost_q, 0), 10);
    chk("d10_gap1", gap(ost_q, 1), 10);
    chk("d3_gap2", gap(ost_q, 2), 3);
    chk("d3_gap3", gap(ost_q, 3), 3);

    // Divisor 0 written while running, then 5
    cycle(1, 1, 0);
    repeat (6) cycle(1, 0, 0);
    chk("zero_div_zero", int'(div_zero), 1);
    chk("zero_bc", int'(baud_clock), 1);
    clr_cap();
    repeat (8) cycle(1, 0, 0);
    chk("zero_no_ost", ost_q.size(), 0);
    chk("zero_no_bt", bt_q.size(), 0);
    clr_cap();
    ld = cyc + 2;
    cycle(1, 1, 5);
    repeat (12) cycle(1, 0, 0);
    chk("resume_latency", first(ost_q) - ld, 5);

    // en dropped at pre_cnt=2, os_cnt=9 with D=5
    cycle(0, 0, 0);
    clr_cap();
    repeat (47) cycle(1, 0, 0);
    chk("pre_drop_ost_cnt", ost_q.size(), 9);
    chk("pre_drop_bc", int'(baud_clock), 0);
    cycle(0, 0, 0);
    chk("drop_outs", int'({os_tick, baud_tick, baud_clock, div_zero}), 4'b0010);
    clr_cap();
    en_cyc = cyc + 1;
    repeat (12) cycle(1, 0, 0);
    chk("reen_latency", first(ost_q) - en_cyc, 4);

    // Random enables and divisor writes
    repeat (300) begin
      cycle(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 6)));
    end

    // Asynchronous reset mid-period
    cycle(0, 1, 3);
    cycle(0, 0, 0);
    repeat (7) cycle(1, 0, 0);
    async_reset();
    repeat (5) cycle(1, 0, 0);
    chk("post_rst_div_zero", int'(div_zero), 1);
    clr_cap();
    ld = cyc + 2;
    cycle(1, 1, 2);
    repeat (20) cycle(1, 0, 0);
    chk("post_rst_latency", first(ost_q) - ld, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
